// File: rtl/cpu_pkg.sv
// Shared types and constants for the core's front end.
//   fetch_state_t : fetch FSM states (FETCH, WAIT, WAIT_DROP)
//   fetch_entry_t : one fetched instruction with its PC
//   INST_BYTES    : size of one instruction word in bytes
//   DEFAULT_RESET_PC : default first fetch address
//   align_pc()    : clears the byte-offset bits of a PC
package cpu_pkg;

    localparam logic [31:0] INST_BYTES       = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        WAIT      = 2'd1,
        WAIT_DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched instructions feeding decode.
//   clk, rst   : clock and synchronous active-high reset
//   flush      : drop all entries next cycle (wins over push)
//   push       : enqueue push_data (never asserted while full without a pop)
//   pop        : dequeue head (ignored when empty)
//   head       : registered head entry, all-zero when empty
//   count      : number of valid entries
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count
);

    fetch_entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [CNT_W-1:0]       count_after_pop_s;
    fetch_entry_t           head_q, head_d;
    logic                   do_pop_s;
    logic                   do_push_s;

    assign do_pop_s          = pop && (count_q != {CNT_W{1'b0}});
    assign do_push_s         = push && ((count_q != CNT_W'(DEPTH)) || do_pop_s);
    assign count_after_pop_s = do_pop_s ? (count_q - CNT_W'(1)) : count_q;

    // Next pointers, occupancy and registered head entry.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        head_d   = '0;
        if (flush) begin
            rd_ptr_d = {PTR_W{1'b0}};
            wr_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
            head_d   = '0;
        end else begin
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                count_d  = count_after_pop_s + CNT_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
                count_d  = count_after_pop_s;
            end
            // A push into a queue that is empty after this cycle's pop becomes
            // the head directly, since it is not in the array yet.
            if (count_d == {CNT_W{1'b0}}) begin
                head_d = '0;
            end else if (do_push_s && (count_after_pop_s == {CNT_W{1'b0}})) begin
                head_d = push_data;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Pointer, count and head registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // Storage array write port; contents are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush && !rst) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = head_q;
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: issues one request at a time to instruction
// memory, queues returned words with their PCs for decode, and handles
// redirects including dropping a stale in-flight response.
//   clk, rst                          : clock, synchronous active-high reset
//   imem_req_valid/ready/addr         : request channel to instruction memory
//   imem_resp_valid/data              : in-order response channel
//   redirect_valid/pc                 : taken branch/jump, flush and refetch
//   inst_valid/ready/pc/data          : instruction stream to decode
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data
);

    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_t       state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]   q_count_s;
    fetch_entry_t       q_head_s;
    fetch_entry_t       push_entry_s;
    logic               push_s;
    logic               pop_s;
    logic               req_hs_s;

    // Issue only from FETCH and only with room for the answer in the queue,
    // so a response can always be pushed.
    assign imem_req_valid = !rst && (state_q == FETCH) && (q_count_s < CNT_W'(QUEUE_DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_hs_s       = imem_req_valid && imem_req_ready;

    assign push_s       = (state_q == WAIT) && imem_resp_valid && !redirect_valid;
    assign push_entry_s = '{pc: fetch_pc_q, inst: imem_resp_data};
    assign pop_s        = inst_valid && inst_ready;

    assign inst_valid = !rst && (q_count_s != {CNT_W{1'b0}});
    assign inst_pc    = rst ? 32'h0000_0000 : q_head_s.pc;
    assign inst_data  = rst ? 32'h0000_0000 : q_head_s.inst;

    // Fetch FSM and PC update.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            FETCH: begin
                // A response seen here is a protocol violation and is ignored.
                if (req_hs_s && redirect_valid) begin
                    state_d    = WAIT_DROP;
                    fetch_pc_d = align_pc(redirect_pc);
                end else if (req_hs_s) begin
                    state_d    = WAIT;
                    fetch_pc_d = fetch_pc_q;
                end else if (redirect_valid) begin
                    state_d    = FETCH;
                    fetch_pc_d = align_pc(redirect_pc);
                end else begin
                    state_d    = FETCH;
                    fetch_pc_d = fetch_pc_q;
                end
            end
            WAIT: begin
                if (imem_resp_valid && redirect_valid) begin
                    state_d    = FETCH;
                    fetch_pc_d = align_pc(redirect_pc);
                end else if (imem_resp_valid) begin
                    state_d    = FETCH;
                    fetch_pc_d = fetch_pc_q + INST_BYTES;
                end else if (redirect_valid) begin
                    state_d    = WAIT_DROP;
                    fetch_pc_d = align_pc(redirect_pc);
                end else begin
                    state_d    = WAIT;
                    fetch_pc_d = fetch_pc_q;
                end
            end
            WAIT_DROP: begin
                if (imem_resp_valid) begin
                    state_d = FETCH;
                end else begin
                    state_d = WAIT_DROP;
                end
                if (redirect_valid) begin
                    fetch_pc_d = align_pc(redirect_pc);
                end else begin
                    fetch_pc_d = fetch_pc_q;
                end
            end
            default: begin
                state_d    = FETCH;
                fetch_pc_d = fetch_pc_q;
            end
        endcase
    end

    // State and fetch PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head      (q_head_s),
        .count     (q_count_s)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A bench-side instruction memory answers
// each accepted request with addr ^ 32'hA5A5_0000 after a chosen latency. A
// scoreboard of expected queued instructions, the expected next fetch address
// and an outstanding/stale flag predict every output each cycle.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;

    fetch_unit #(
        .RESET_PC    (RST_PC),
        .QUEUE_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_pc         (inst_pc),
        .inst_data       (inst_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_mis;

    // Reference model state
    logic [63:0] exp_q[$];      // {pc, data} expected in decode order
    logic [31:0] exp_fetch_pc;
    bit          outstanding;
    bit          stale;
    // Bench memory state
    bit          mem_pending;
    int          mem_delay;
    logic [31:0] mem_addr;
    int          lat_lo;
    int          lat_hi;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_fetch_pc = RST_PC;
        outstanding  = 1'b0;
        stale        = 1'b0;
        mem_pending  = 1'b0;
        mem_delay    = 0;
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        rst             = 1'b1;
        inst_ready      = 1'b1;
        imem_req_ready  = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        #1;
        check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_inst_data", inst_data, 32'h0);
        model_reset();
        @(posedge clk);
    endtask

    task automatic step(input logic rdy, input logic mrdy, input logic rdr,
                        input logic [31:0] rpc, input logic spur);
        bit          resp;
        bit          exp_rv;
        logic [31:0] rdata;
        logic [63:0] head;
        @(negedge clk);
        rst            = 1'b0;
        inst_ready     = rdy;
        imem_req_ready = mrdy;
        redirect_valid = rdr;
        redirect_pc    = rpc;
        resp = mem_pending && (mem_delay == 0);
        if (mem_pending && (mem_delay != 0)) mem_delay--;
        rdata = mem_addr ^ 32'hA5A5_0000;
        imem_resp_valid = resp || (spur && !outstanding);
        imem_resp_data  = resp ? rdata : $urandom;
        #1;
        exp_rv = !outstanding && (exp_q.size() < DEPTH);
        check("req_valid", {31'h0, imem_req_valid}, {31'h0, exp_rv});
        if (exp_rv) check("req_addr", imem_req_addr, exp_fetch_pc);
        head = (exp_q.size() != 0) ? exp_q[0] : 64'h0;
        check("inst_valid", {31'h0, inst_valid}, {31'h0, exp_q.size() != 0});
        check("inst_pc", inst_pc, head[63:32]);
        check("inst_data", inst_data, head[31:0]);
        // Predict the effect of this cycle's events.
        if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
        if (resp) begin
            mem_pending = 1'b0;
            outstanding = 1'b0;
            if (!stale && !rdr) begin
                exp_q.push_back({mem_addr, rdata});
                exp_fetch_pc = mem_addr + 32'd4;
            end
        end
        if (exp_rv && mrdy) begin
            outstanding = 1'b1;
            stale       = 1'b0;
            mem_pending = 1'b1;
            mem_addr    = exp_fetch_pc;
            mem_delay   = $urandom_range(lat_hi, lat_lo) - 1;
        end
        if (rdr) begin
            exp_q.delete();
            exp_fetch_pc = {rpc[31:2], 2'b00};
            if (outstanding) stale = 1'b1;
        end
        @(posedge clk);
    endtask

    task automatic run_until_outstanding();
        for (int i = 0; i < 8 && !outstanding; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        n_vec  = 0;
        n_mis  = 0;
        lat_lo = 1;
        lat_hi = 1;
        mem_addr = 32'h0;
        model_reset();

        // Reset then streaming with ready decode and 1-cycle memory.
        reset_cycle();
        reset_cycle();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // Backpressure: queue fills to two entries, then drains.
        reset_cycle();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // Redirect in WAIT before the response arrives (2-cycle memory).
        lat_lo = 2; lat_hi = 2;
        run_until_outstanding();
        step(1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // Redirect coincident with the response.
        lat_lo = 1; lat_hi = 1;
        run_until_outstanding();
        step(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // Request stall with a redirect in the middle.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0040, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // Address wrap, redirect with non-zero byte offset.
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // Reset while a request is outstanding with a queued entry.
        lat_lo = 2; lat_hi = 2;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        run_until_outstanding();
        reset_cycle();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // Randomized traffic: variable latency, stalls, redirects, stray responses.
        lat_lo = 1; lat_hi = 3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499, 0) == 0) begin
                reset_cycle();
            end else begin
                step($urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0,
                     $urandom_range(11, 0) == 0, $urandom,
                     $urandom_range(9, 0) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
